// File: rtl/order_msg_decoder.sv
// order_msg_decoder: unpacks fixed 12-byte order messages from a byte stream
// into one-entry registered order outputs, gated by the order book's busy flag.
module order_msg_decoder #(
    parameter int NUM_STOCKS = 4,
    parameter int MSG_BYTES  = 12,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic [7:0]           i_byte,
    input  logic                 i_byte_valid,
    output logic                 o_byte_ready,
    input  logic                 i_book_busy,
    output logic                 o_order_valid,
    output logic [1:0]           o_stock_id,
    output logic [1:0]           o_order_type,
    output logic [15:0]          o_quantity,
    output logic [31:0]          o_price,
    output logic [31:0]          o_order_id,
    output logic [CNT_WIDTH-1:0] o_drop_count
);

    localparam logic [3:0] LAST_K      = 4'(MSG_BYTES - 1);
    localparam logic [8:0] STOCK_LIMIT = 9'(NUM_STOCKS);

    typedef enum logic {IDLE, PAYLOAD} state_t;
    typedef enum logic [1:0] {ADD = 2'd0, CANCEL = 2'd1, EXECUTE = 2'd2} order_type_t;

    state_t                state_q, state_d;
    logic [3:0]            k_q, k_d;
    // Holds payload bytes k2..k10 once k10 has been shifted in
    logic [71:0]           payload_q, payload_d;
    order_type_t           msg_type_q, msg_type_d;
    logic [1:0]            msg_stock_q, msg_stock_d;
    logic                  bad_q, bad_d;

    logic                  order_valid_q, order_valid_d;
    logic [1:0]            stock_q, stock_d;
    order_type_t           order_type_q, order_type_d;
    logic [15:0]           quantity_q, quantity_d;
    logic [31:0]           price_q, price_d;
    logic [31:0]           order_id_q, order_id_d;
    logic [CNT_WIDTH-1:0]  drop_q, drop_d;

    logic                  byte_ready;
    logic                  accept;
    logic                  transfer;
    logic                  load;
    logic                  drop_inc;
    logic [79:0]           msg;

    // Next-state: byte acceptance, parsing FSM, commit, output register and drop counter
    always_comb begin
        byte_ready    = !(state_q == PAYLOAD && k_q == LAST_K && order_valid_q && i_book_busy);
        accept        = i_byte_valid && byte_ready;
        transfer      = order_valid_q && !i_book_busy;
        // Final byte is combined with the shift register so commit needs no extra cycle
        msg           = {payload_q, i_byte};
        load          = 1'b0;
        drop_inc      = 1'b0;
        state_d       = state_q;
        k_d           = k_q;
        payload_d     = payload_q;
        msg_type_d    = msg_type_q;
        msg_stock_d   = msg_stock_q;
        bad_d         = bad_q;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (i_byte == 8'h41 || i_byte == 8'h58 || i_byte == 8'h45) begin
                        msg_type_d = (i_byte == 8'h41) ? ADD :
                                     (i_byte == 8'h58) ? CANCEL : EXECUTE;
                        bad_d      = 1'b0;
                        k_d        = 4'd1;
                        state_d    = PAYLOAD;
                    end else begin
                        drop_inc = 1'b1;
                    end
                end
            end
            PAYLOAD: begin
                if (accept) begin
                    if (k_q == 4'd1) begin
                        msg_stock_d = i_byte[1:0];
                        bad_d       = ({1'b0, i_byte} >= STOCK_LIMIT);
                    end
                    if (k_q == LAST_K) begin
                        state_d = IDLE;
                        k_d     = '0;
                        if (bad_q || (msg_type_q == ADD && msg[47:32] == 16'd0))
                            drop_inc = 1'b1;
                        else
                            load = 1'b1;
                    end else begin
                        payload_d = {payload_q[63:0], i_byte};
                        k_d       = k_q + 4'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                k_d     = '0;
            end
        endcase

        order_valid_d = order_valid_q;
        stock_d       = stock_q;
        order_type_d  = order_type_q;
        quantity_d    = quantity_q;
        price_d       = price_q;
        order_id_d    = order_id_q;
        if (load) begin
            order_valid_d = 1'b1;
            stock_d       = msg_stock_q;
            order_type_d  = msg_type_q;
            order_id_d    = msg[79:48];
            quantity_d    = msg[47:32];
            price_d       = msg[31:0];
        end else if (transfer) begin
            order_valid_d = 1'b0;
            stock_d       = '0;
            order_type_d  = ADD;
            quantity_d    = '0;
            price_d       = '0;
            order_id_d    = '0;
        end

        drop_d = drop_q;
        if (drop_inc && drop_q != '1)
            drop_d = drop_q + 1'b1;
    end

    // State and output registers with synchronous reset
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q       <= IDLE;
            k_q           <= '0;
            payload_q     <= '0;
            msg_type_q    <= ADD;
            msg_stock_q   <= '0;
            bad_q         <= 1'b0;
            order_valid_q <= 1'b0;
            stock_q       <= '0;
            order_type_q  <= ADD;
            quantity_q    <= '0;
            price_q       <= '0;
            order_id_q    <= '0;
            drop_q        <= '0;
        end else begin
            state_q       <= state_d;
            k_q           <= k_d;
            payload_q     <= payload_d;
            msg_type_q    <= msg_type_d;
            msg_stock_q   <= msg_stock_d;
            bad_q         <= bad_d;
            order_valid_q <= order_valid_d;
            stock_q       <= stock_d;
            order_type_q  <= order_type_d;
            quantity_q    <= quantity_d;
            price_q       <= price_d;
            order_id_q    <= order_id_d;
            drop_q        <= drop_d;
        end
    end

    assign o_byte_ready  = byte_ready;
    assign o_order_valid = order_valid_q;
    assign o_stock_id    = stock_q;
    assign o_order_type  = order_type_q;
    assign o_quantity    = quantity_q;
    assign o_price       = price_q;
    assign o_order_id    = order_id_q;
    assign o_drop_count  = drop_q;

endmodule

// File: tb/tb_order_msg_decoder.sv
// tb_order_msg_decoder: directed stimulus with a scoreboard queue of expected
// orders; a monitor process compares each presented order.
module tb_order_msg_decoder;

    logic        clk = 1'b0;
    logic        i_reset;
    logic [7:0]  i_byte;
    logic        i_byte_valid;
    logic        o_byte_ready;
    logic        i_book_busy;
    logic        o_order_valid;
    logic [1:0]  o_stock_id;
    logic [1:0]  o_order_type;
    logic [15:0] o_quantity;
    logic [31:0] o_price;
    logic [31:0] o_order_id;
    logic [15:0] o_drop_count;

    typedef struct packed {
        logic [1:0]  stock;
        logic [1:0]  otype;
        logic [15:0] qty;
        logic [31:0] price;
        logic [31:0] id;
    } order_t;

    order_t exp_q[$];
    int     checks = 0;
    int     errors = 0;

    order_msg_decoder #(
        .NUM_STOCKS(4),
        .MSG_BYTES (12),
        .CNT_WIDTH (16)
    ) dut (
        .i_clk        (clk),
        .i_reset      (i_reset),
        .i_byte       (i_byte),
        .i_byte_valid (i_byte_valid),
        .o_byte_ready (o_byte_ready),
        .i_book_busy  (i_book_busy),
        .o_order_valid(o_order_valid),
        .o_stock_id   (o_stock_id),
        .o_order_type (o_order_type),
        .o_quantity   (o_quantity),
        .o_price      (o_price),
        .o_order_id   (o_order_id),
        .o_drop_count (o_drop_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: compare presented order against queue head; pop on transfer
    always @(negedge clk) begin
        if (!i_reset && o_order_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_order", 1'b1, 1'b0);
            end else begin
                chk("order_fields",
                    {o_stock_id, o_order_type, o_quantity, o_price, o_order_id},
                    exp_q[0]);
                if (!i_book_busy)
                    void'(exp_q.pop_front());
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, output int stall);
        stall        = 0;
        i_byte       = b;
        i_byte_valid = 1'b1;
        @(negedge clk);
        while (!o_byte_ready && stall < 100) begin
            stall++;
            @(negedge clk);
        end
        if (stall >= 100)
            chk("ready_timeout", 1'b0, 1'b1);
        @(posedge clk);
        #1;
        i_byte_valid = 1'b0;
    endtask

    // Sends a 12-byte message; reports stalls on bytes 0-10 and on byte 11 separately
    task automatic send_msg(input logic [7:0] t, input logic [7:0] stk, input logic [31:0] id,
                            input logic [15:0] qty, input logic [31:0] price,
                            output int stall_early, output int stall_last);
        logic [87:0] body;
        int          s;
        body        = {stk, id, qty, price};
        stall_early = 0;
        send_byte(t, s);
        stall_early += s;
        for (int i = 0; i < 10; i++) begin
            send_byte(body[87 - 8*i -: 8], s);
            stall_early += s;
        end
        send_byte(body[7:0], stall_last);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        int se, sl, dummy;
        i_reset      = 1'b1;
        i_byte       = 8'h00;
        i_byte_valid = 1'b0;
        i_book_busy  = 1'b0;
        wait_cycles(3);
        i_reset = 1'b0;
        #1;
        chk("reset_valid", o_order_valid, 1'b0);
        chk("reset_fields", {o_stock_id, o_order_type, o_quantity, o_price, o_order_id}, '0);
        chk("reset_drop", o_drop_count, 16'd0);
        chk("reset_ready", o_byte_ready, 1'b1);

        // 1: basic ADD, valid one cycle after final byte
        exp_q.push_back('{2'd2, 2'd0, 16'd100, 32'd1000, 32'd7});
        send_msg(8'h41, 8'h02, 32'd7, 16'h0064, 32'h000003E8, se, sl);
        chk("t1_valid_latency", o_order_valid, 1'b1);
        chk("t1_no_stall", se + sl, 0);
        wait_cycles(2);
        chk("t1_valid_dropped", o_order_valid, 1'b0);

        // 2: held while busy, transfers on first !busy cycle
        i_book_busy = 1'b1;
        exp_q.push_back('{2'd1, 2'd0, 16'd5, 32'h11223344, 32'd8});
        send_msg(8'h41, 8'h01, 32'd8, 16'd5, 32'h11223344, se, sl);
        chk("t2_no_stall", se + sl, 0);
        chk("t2_valid", o_order_valid, 1'b1);
        wait_cycles(5);
        chk("t2_held", o_order_valid, 1'b1);
        i_book_busy = 1'b0;
        wait_cycles(1);
        chk("t2_valid_after_transfer", o_order_valid, 1'b0);

        // 3: next message streams while busy; stalls only on its final byte
        i_book_busy = 1'b1;
        exp_q.push_back('{2'd3, 2'd0, 16'h1234, 32'hDEADBEEF, 32'd9});
        send_msg(8'h41, 8'h03, 32'd9, 16'h1234, 32'hDEADBEEF, se, sl);
        exp_q.push_back('{2'd1, 2'd1, 16'd1, 32'd2, 32'd7});
        fork
            send_msg(8'h58, 8'h01, 32'd7, 16'd1, 32'd2, se, sl);
            begin
                repeat (15) @(posedge clk);
                #1;
                i_book_busy = 1'b0;
            end
        join
        chk("t3_early_no_stall", se, 0);
        chk("t3_last_stalled", sl > 0, 1'b1);
        chk("t3_back_to_back_valid", o_order_valid, 1'b1);
        wait_cycles(2);
        chk("t3_drained", o_order_valid, 1'b0);

        // 4: bad stock dropped, unknown type byte dropped, next byte parsed as type
        send_msg(8'h45, 8'h05, 32'd1, 16'd1, 32'd1, se, sl);
        chk("t4_bad_stock_drop", o_drop_count, 16'd1);
        chk("t4_bad_stock_no_valid", o_order_valid, 1'b0);
        send_byte(8'h5A, dummy);
        chk("t4_unknown_type_drop", o_drop_count, 16'd2);
        exp_q.push_back('{2'd0, 2'd0, 16'hFFFF, 32'hFFFFFFFF, 32'h0A0B0C0D});
        send_msg(8'h41, 8'h00, 32'h0A0B0C0D, 16'hFFFF, 32'hFFFFFFFF, se, sl);
        chk("t4_resync_valid", o_order_valid, 1'b1);
        chk("t4_drop_unchanged", o_drop_count, 16'd2);
        wait_cycles(2);
        exp_q.push_back('{2'd3, 2'd2, 16'd0, 32'd5, 32'd0});
        send_msg(8'h45, 8'h03, 32'd0, 16'd0, 32'd5, se, sl);
        chk("t4_execute_qty0_kept", o_order_valid, 1'b1);
        wait_cycles(2);

        // 5: ADD with zero quantity dropped
        send_msg(8'h41, 8'h03, 32'd4, 16'd0, 32'd9, se, sl);
        chk("t5_add_qty0_drop", o_drop_count, 16'd3);
        wait_cycles(1);
        chk("t5_add_qty0_no_valid", o_order_valid, 1'b0);

        // 6: reset mid-message, then fresh message decodes
        send_byte(8'h41, dummy);
        send_byte(8'h01, dummy);
        for (int i = 0; i < 4; i++) send_byte(8'h00, dummy);
        i_reset = 1'b1;
        wait_cycles(1);
        i_reset = 1'b0;
        chk("t6_reset_valid", o_order_valid, 1'b0);
        chk("t6_reset_fields", {o_stock_id, o_order_type, o_quantity, o_price, o_order_id}, '0);
        chk("t6_reset_drop", o_drop_count, 16'd0);
        chk("t6_reset_ready", o_byte_ready, 1'b1);
        exp_q.push_back('{2'd2, 2'd1, 16'd3, 32'h00000100, 32'h00000063});
        send_msg(8'h58, 8'h02, 32'h63, 16'd3, 32'h100, se, sl);
        chk("t6_fresh_valid", o_order_valid, 1'b1);
        wait_cycles(2);

        // Saturation of the drop counter
        i_byte       = 8'h00;
        i_byte_valid = 1'b1;
        wait_cycles(65534);
        chk("sat_fffe", o_drop_count, 16'hFFFE);
        wait_cycles(1);
        chk("sat_ffff", o_drop_count, 16'hFFFF);
        wait_cycles(3);
        chk("sat_hold", o_drop_count, 16'hFFFF);
        i_byte_valid = 1'b0;
        wait_cycles(2);

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
